mem_arbiter: RTL and testbench

- Arbitrates the 16x8 program/data RAM between two requesters: port 0 (CPU fetch/execute) and port 1 (program loader/DMA).
- Sequences every access as a single one-cycle RAM read or write strobe, captures read data and returns a one-cycle ack.
- Sits between the CPU control unit and the RAM. It is the only driver of the RAM read/write/addr/data_in pins.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/mem_arbiter_arb_rr2.sv | 35 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the program/data RAM arbiter: RAM geometry,
// arbiter FSM state encoding and requester port ids.
// ----------------------------------------------------------------------------
package mem_pkg;

    localparam int ADDR_W = 4;  // 16 RAM locations
    localparam int DATA_W = 8;  // RAM word width

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Requester ids, also the encoding of the grant output.
    localparam logic PORT_CPU = 1'b0;  // CPU fetch/execute
    localparam logic PORT_LDR = 1'b1;  // program loader / DMA

endpackage

// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles both requester handshakes, the RAM pins and the arbiter status.
//   req0/we0/addr0/wdata0 -> ack0/rdata0 : port 0 (CPU)
//   req1/we1/addr1/wdata1 -> ack1/rdata1 : port 1 (loader/DMA)
//   ram_read/ram_write/ram_addr/ram_wdata : RAM strobes and bus, arbiter driven
//   ram_rdata                             : combinational RAM read data
//   busy/grant                            : arbiter status
// Modports: slave = arbiter side, master = requesters + RAM side.
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
);

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic              ram_read;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;
    logic              grant;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_rdata,
        output ack0, rdata0, ack1, rdata1,
        output ram_read, ram_write, ram_addr, ram_wdata,
        output busy, grant
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  ram_read, ram_write, ram_addr, ram_wdata,
        input  busy, grant
    );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// ----------------------------------------------------------------------------
// arb_rr2
// Two-way combinational grant pick.
//   req0, req1 : pending requests
//   last_gnt   : id of the port that owned the previous transaction
//   gnt_valid  : at least one request pending
//   gnt_id     : winning port id
// A lone requester always wins. On a tie the port that did not win last
// time wins, unless FIXED_PRIO is set, in which case port 0 always wins.
// ----------------------------------------------------------------------------
module arb_rr2
    import mem_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        // NOTE: every output gets a default before the branches, so no path
        // leaves it unassigned and no latch is inferred.
        gnt_valid = req0 | req1;
        gnt_id    = PORT_CPU;
        if (req0 && req1) begin
            gnt_id = FIXED_PRIO ? PORT_CPU : ~last_gnt;
        end else if (req1) begin
            gnt_id = PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates the 16x8 program/data RAM between the CPU (port 0) and the
// program loader/DMA (port 1). Each access is one IDLE -> ACCESS -> RESP
// pass: a one-cycle RAM read or write strobe in ACCESS, then a one-cycle
// ack to the owning port in RESP. All outputs are registered.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : requester handshakes, RAM pins, busy/grant (slave modport)
// ADDR_W/DATA_W must match the widths of the connected interface.
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W     = mem_pkg::ADDR_W,
    parameter int DATA_W     = mem_pkg::DATA_W,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    import mem_pkg::*;

    state_t            state;
    logic              op_we;
    logic              grant_q;
    logic              busy_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              ram_read_q;
    logic              ram_write_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              pick_valid;
    logic              pick_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    arb_rr2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req0      (bus.req0),
        .req1      (bus.req1),
        .last_gnt  (grant_q),
        .gnt_valid (pick_valid),
        .gnt_id    (pick_id)
    );

    // Operands of whichever port wins the pick this cycle.
    assign sel_we    = (pick_id == PORT_LDR) ? bus.we1    : bus.we0;
    assign sel_addr  = (pick_id == PORT_LDR) ? bus.addr1  : bus.addr0;
    assign sel_wdata = (pick_id == PORT_LDR) ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_we       <= 1'b0;
            // Reset grant to port 1 so that port 0 takes the first tie.
            grant_q     <= PORT_LDR;
            busy_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            // NOTE: these are plain output registers, not a storage array,
            // so resetting them is cheap and gives a defined first value.
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; every register
            // updates from pre-edge values, so statement order is irrelevant.
            // Strobes and acks are single-cycle pulses by default.
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q     <= pick_id;
                        op_we       <= sel_we;
                        ram_addr_q  <= sel_addr;
                        ram_wdata_q <= sel_wdata;
                        // Strobe is registered so it is high exactly for ACCESS.
                        ram_read_q  <= ~sel_we;
                        ram_write_q <= sel_we;
                        busy_q      <= 1'b1;
                        state       <= ACCESS;
                    end
                end

                ACCESS: begin
                    // RAM read data is combinational from the stable address.
                    if (!op_we) begin
                        if (grant_q == PORT_CPU) begin
                            rdata0_q <= bus.ram_rdata;
                        end else begin
                            rdata1_q <= bus.ram_rdata;
                        end
                    end
                    ack0_q <= (grant_q == PORT_CPU);
                    ack1_q <= (grant_q == PORT_LDR);
                    state  <= RESP;
                end

                RESP: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.ram_read  = ram_read_q;
    assign bus.ram_write = ram_write_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiter instances: instance 0 in round-robin mode, instance 1 with
// fixed priority, each with its own RAM model. Requester tasks issue a
// directed vector table and push the expected response into a scoreboard
// queue; a per-instance monitor pops and compares on every ack.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

    typedef struct {
        int         d;
        int         p;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
        int         lat;
    } vec_t;

    typedef struct {
        int         d;
        int         p;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         issue;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ram_init;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic       req   [2][2];
    logic       we    [2][2];
    logic [3:0] addr  [2][2];
    logic [7:0] wdata [2][2];

    logic       ack_o    [2][2];
    logic [7:0] rdata_o  [2][2];
    logic       rd_o     [2];
    logic       wr_o     [2];
    logic       busy_o   [2];
    logic       gnt_o    [2];
    logic [3:0] raddr_o  [2];
    logic [7:0] rwdata_o [2];

    logic [7:0] last_rd [2][2];
    vec_t       tv [18];
    exp_t       exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    mem_arbiter_if bus [2] ();

    for (genvar d = 0; d < 2; d++) begin : g_dut
        logic [7:0] mem [16];
        int         scnt;
        logic       s_we;
        logic [3:0] s_addr;
        logic [7:0] s_wdata;
        int         p;
        int         idx;
        exp_t       e;

        mem_arbiter #(
            .FIXED_PRIO (d == 1)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[d])
        );

        assign bus[d].req0   = req[d][0];
        assign bus[d].we0    = we[d][0];
        assign bus[d].addr0  = addr[d][0];
        assign bus[d].wdata0 = wdata[d][0];
        assign bus[d].req1   = req[d][1];
        assign bus[d].we1    = we[d][1];
        assign bus[d].addr1  = addr[d][1];
        assign bus[d].wdata1 = wdata[d][1];

        assign ack_o[d][0]   = bus[d].ack0;
        assign ack_o[d][1]   = bus[d].ack1;
        assign rdata_o[d][0] = bus[d].rdata0;
        assign rdata_o[d][1] = bus[d].rdata1;
        assign rd_o[d]       = bus[d].ram_read;
        assign wr_o[d]       = bus[d].ram_write;
        assign busy_o[d]     = bus[d].busy;
        assign gnt_o[d]      = bus[d].grant;
        assign raddr_o[d]    = bus[d].ram_addr;
        assign rwdata_o[d]   = bus[d].ram_wdata;

        // RAM model: known contents at 2, 10, 11, 12; writes on the strobe.
        assign bus[d].ram_rdata = mem[bus[d].ram_addr];
        always @(posedge clk) begin
            if (ram_init) begin
                for (int i = 0; i < 16; i++) mem[i] <= 8'h40 + 8'(i);
                mem[2]  <= 8'h26;
                mem[10] <= 8'h1B;
                mem[11] <= 8'h0B;
                mem[12] <= 8'h1C;
            end else if (bus[d].ram_write) begin
                mem[bus[d].ram_addr] <= bus[d].ram_wdata;
            end
        end

        // Monitor: records the strobe cycle, then checks it against the
        // scoreboard entry popped when the ack arrives.
        always @(negedge clk) begin
            if (rst) begin
                scnt <= 0;
            end else begin
                check($sformatf("strobe_overlap_d%0d", d), 32'(rd_o[d] & wr_o[d]), 32'd0);
                check($sformatf("ack_overlap_d%0d", d), 32'(ack_o[d][0] & ack_o[d][1]), 32'd0);
                if (ack_o[d][0] || ack_o[d][1]) begin
                    p   = ack_o[d][1] ? 1 : 0;
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (idx < 0 && exp_q[i].d == d && exp_q[i].p == p) idx = i;
                    check($sformatf("ack_expected_d%0d_p%0d", d, p), 32'(idx >= 0), 32'd1);
                    if (idx >= 0) begin
                        e = exp_q[idx];
                        exp_q.delete(idx);
                        check($sformatf("strobe_cycles_d%0d", d), scnt, 1);
                        check($sformatf("strobe_we_d%0d", d), 32'(s_we), 32'(e.we));
                        check($sformatf("ram_addr_d%0d", d), 32'(s_addr), 32'(e.addr));
                        if (e.we) check($sformatf("ram_wdata_d%0d", d), 32'(s_wdata), 32'(e.wdata));
                        check($sformatf("strobe_low_at_ack_d%0d", d), 32'(rd_o[d] | wr_o[d]), 32'd0);
                        check($sformatf("grant_d%0d", d), 32'(gnt_o[d]), p);
                        check($sformatf("busy_at_ack_d%0d", d), 32'(busy_o[d]), 32'd1);
                        check($sformatf("rdata_d%0d_p%0d", d, p), 32'(rdata_o[d][p]), 32'(e.rdata));
                        check($sformatf("latency_d%0d_p%0d", d, p), cyc - e.issue, e.lat);
                    end
                    scnt <= 0;
                end else if (rd_o[d] || wr_o[d]) begin
                    check($sformatf("busy_at_strobe_d%0d", d), 32'(busy_o[d]), 32'd1);
                    scnt    <= scnt + 1;
                    s_we    <= wr_o[d];
                    s_addr  <= raddr_o[d];
                    s_wdata <= rwdata_o[d];
                end
            end
        end
    end

    task automatic wait_ack(input int d, input int p);
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (ack_o[d][p]) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout_d%0d_p%0d: got no ack, required one within 60 cycles", d, p);
        end
    endtask

    // Issues tv[first..last] back-to-back from one port, holding req high
    // across consecutive requests and dropping it on the final ack edge.
    task automatic drive_seq(input int first, input int last);
        int   d = tv[first].d;
        int   p = tv[first].p;
        exp_t x;
        for (int i = first; i <= last; i++) begin
            req[d][p]   = 1'b1;
            we[d][p]    = tv[i].we;
            addr[d][p]  = tv[i].addr;
            wdata[d][p] = tv[i].wdata;
            if (!tv[i].we) last_rd[d][p] = tv[i].rd;
            x = '{d: d, p: p, we: tv[i].we, addr: tv[i].addr, wdata: tv[i].wdata,
                  rdata: last_rd[d][p], issue: cyc, lat: tv[i].lat};
            exp_q.push_back(x);
            wait_ack(d, p);
            @(posedge clk);
            #1;
        end
        req[d][p] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish by 200000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        //           d  p  we    addr   wdata  rd     lat
        tv[0]  = '{0, 0, 1'b0, 4'd2,  8'h00, 8'h26, 2};   // lone CPU read
        tv[1]  = '{0, 1, 1'b1, 4'd5,  8'hA5, 8'h00, 2};   // loader write
        tv[2]  = '{0, 0, 1'b0, 4'd5,  8'h00, 8'hA5, 2};   // CPU reads it back
        tv[3]  = '{0, 0, 1'b0, 4'd2,  8'h00, 8'h26, 5};   // RR, both held:
        tv[4]  = '{0, 0, 1'b0, 4'd10, 8'h00, 8'h1B, 5};   // last grant was 0,
        tv[5]  = '{0, 0, 1'b0, 4'd11, 8'h00, 8'h0B, 5};   // so port 1 leads
        tv[6]  = '{0, 1, 1'b0, 4'd12, 8'h00, 8'h1C, 2};
        tv[7]  = '{0, 1, 1'b0, 4'd5,  8'h00, 8'hA5, 5};
        tv[8]  = '{0, 1, 1'b0, 4'd2,  8'h00, 8'h26, 5};
        tv[9]  = '{1, 0, 1'b0, 4'd2,  8'h00, 8'h26, 2};   // fixed priority
        tv[10] = '{1, 0, 1'b0, 4'd10, 8'h00, 8'h1B, 2};
        tv[11] = '{1, 0, 1'b0, 4'd11, 8'h00, 8'h0B, 2};
        tv[12] = '{1, 1, 1'b0, 4'd12, 8'h00, 8'h1C, 11};  // starved 3 txns
        tv[13] = '{0, 0, 1'b0, 4'd2,  8'h00, 8'h26, 2};   // tie after reset
        tv[14] = '{0, 1, 1'b0, 4'd10, 8'h00, 8'h1B, 5};
        tv[15] = '{0, 1, 1'b0, 4'd10, 8'h00, 8'h1B, 2};   // lone loader reads
        tv[16] = '{0, 1, 1'b0, 4'd11, 8'h00, 8'h0B, 2};
        tv[17] = '{0, 1, 1'b0, 4'd12, 8'h00, 8'h1C, 2};

        rst      = 1'b1;
        ram_init = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                req[d][p]     = 1'b0;
                we[d][p]      = 1'b0;
                addr[d][p]    = 4'd0;
                wdata[d][p]   = 8'd0;
                last_rd[d][p] = 8'd0;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_busy_d%0d", d), 32'(busy_o[d]), 32'd0);
            check($sformatf("rst_ack0_d%0d", d), 32'(ack_o[d][0]), 32'd0);
            check($sformatf("rst_ack1_d%0d", d), 32'(ack_o[d][1]), 32'd0);
            check($sformatf("rst_read_d%0d", d), 32'(rd_o[d]), 32'd0);
            check($sformatf("rst_write_d%0d", d), 32'(wr_o[d]), 32'd0);
            check($sformatf("rst_addr_d%0d", d), 32'(raddr_o[d]), 32'd0);
            check($sformatf("rst_wdata_d%0d", d), 32'(rwdata_o[d]), 32'd0);
            check($sformatf("rst_rdata0_d%0d", d), 32'(rdata_o[d][0]), 32'd0);
            check($sformatf("rst_rdata1_d%0d", d), 32'(rdata_o[d][1]), 32'd0);
            check($sformatf("rst_grant_d%0d", d), 32'(gnt_o[d]), 32'd1);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        ram_init = 1'b0;
        idle(1);

        drive_seq(0, 0);
        idle(2);
        drive_seq(1, 1);
        drive_seq(2, 2);
        idle(2);
        fork
            drive_seq(3, 5);
            drive_seq(6, 8);
        join
        idle(2);
        fork
            drive_seq(9, 11);
            drive_seq(12, 12);
        join
        idle(2);

        // Reset during the ACCESS cycle of a write to addr 7.
        req[0][1]   = 1'b1;
        we[0][1]    = 1'b1;
        addr[0][1]  = 4'd7;
        wdata[0][1] = 8'h77;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (wr_o[0]) seen = 1'b1;
        end
        check("abort_write_strobe_seen", 32'(seen), 32'd1);
        rst       = 1'b1;
        req[0][1] = 1'b0;
        @(negedge clk);
        check("abort_write_low", 32'(wr_o[0]), 32'd0);
        check("abort_read_low", 32'(rd_o[0]), 32'd0);
        check("abort_busy", 32'(busy_o[0]), 32'd0);
        check("abort_ack1", 32'(ack_o[0][1]), 32'd0);
        check("abort_grant", 32'(gnt_o[0]), 32'd1);
        @(negedge clk);
        check("abort_no_late_ack", 32'(ack_o[0][1]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) last_rd[d][p] = 8'd0;
        idle(1);

        fork
            drive_seq(13, 13);
            drive_seq(14, 14);
        join
        idle(2);
        drive_seq(15, 17);
        idle(4);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
